mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Receiving end of the execute-stage result interface: latches the EX/MEM fields and, for loads/stores, runs a request/done handshake against a multi-cycle data memory.
- Delivers a single-cycle writeback packet.
- Back-pressures execute with ex_stall while a memory access is outstanding.
- Sits between execute and writeback in the 16-bit pipeline.

Parameters:
- MEM_TIMEOUT, 16: WAIT cycles allowed for mem_done before an error is reported (≥2).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- ex_valid  in  1  execute presents a packet
- ex_alu_result  in  16  ALU result / memory address
- ex_store_data  in  16  store data
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_reg_write  in  1  destination write enable
- ex_wr_reg  in  3  destination register
- ex_halt  in  1  HALT instruction
- ex_stall  out  1  execute must hold its packet
- mem_req  out  1  memory request valid
- mem_wr  out  1  1=write, 0=read
- mem_addr  out  16  word address
- mem_wdata  out  16  write data
- mem_stall  in  1  memory cannot accept this cycle
- mem_done  in  1  access complete
- mem_rdata  in  16  read data (valid with mem_done)
- wb_valid  out  1  writeback packet valid (1-cycle pulse)
- wb_data  out  16  load data or ALU result
- wb_reg  out  3  destination register
- wb_reg_write  out  1  register write enable
- wb_err  out  1  misaligned, illegal or timed-out access
- wb_halt  out  1  halt reached writeback

Behaviour:
- Reset: state IDLE, counter 0, every output 0 except ex_stall, which is 0 in IDLE.
- States: IDLE, REQ, WAIT, HALTED. ex_stall = (state != IDLE), combinational from state.
- IDLE, ex_valid=1: latch all ex_* fields.
  - ex_halt: wb_valid=1 and wb_halt=1 next cycle; go to HALTED.
  - Neither read nor write: wb_valid=1 next cycle with wb_data=alu_result; stay IDLE. Latency 1; back-to-back accepted.
  - Read and write both set, or address bit 0 = 1 on a memory op: no memory request. wb_valid=1, wb_err=1, wb_reg_write=0 next cycle.
  - Otherwise go to REQ.
- REQ: mem_req=1; mem_wr/mem_addr/mem_wdata come from the latch and stay stable.
  - mem_stall=1: hold in REQ.
  - mem_stall=0: request taken; go to WAIT, counter←0.
- WAIT: mem_req=0.
  - mem_done=1: next cycle wb_valid=1; wb_data = mem_rdata for a load, alu_result for a store; wb_reg_write = latched value AND load; go to IDLE.
  - No mem_done: counter increments. If the MEM_TIMEOUT-th WAIT cycle passes with no mem_done: wb_valid=1, wb_err=1, wb_reg_write=0; go to IDLE.
- mem_done outside WAIT is ignored. The memory never asserts done in the accept cycle.
- HALTED: ex_stall=1; no further packets accepted until rst.
- wb_* outputs are registered. The wb_valid pulse lasts one cycle; wb_data/wb_reg hold until the next packet. The writeback stage never stalls.
- Memory timing: accept in cycle N, REQ in N+1; with no stall, WAIT from N+2; mem_done in cycle D gives wb_valid in D+1.
- rst mid-access drops the transaction: mem_req→0, nothing is written back, and a late mem_done is ignored.

Decomposition:
- Shared package/include: state encoding (2 bits), WORD_W=16, REG_W=3, counter width = clog2(MEM_TIMEOUT)+1.
- Sub-module ex_mem_latch: enable-loaded register bank for the EX/MEM fields, async reset.
- FSM, counter and writeback register stay in the top.

Test Plan:
- Non-memory packet (alu 0x1234, reg 3, reg_write 1), then a second packet the next cycle → wb_valid on consecutive cycles, wb_data 0x1234/wb_reg 3 first, ex_stall never asserted.
- Load from 0x0040, mem_stall 0, mem_done two cycles after the request with rdata 0xBEEF → wb_data 0xBEEF, wb_reg_write 1; ex_stall high exactly during REQ/WAIT.
- Store to 0x0010 with data 0xA5A5, mem_stall held 3 cycles → mem_req, mem_wr=1, address and data stable for 4 cycles; writeback arrives with wb_reg_write 0 and wb_err 0.
- Load from 0x0041, and separately read+write both set → no mem_req; wb_err=1 next cycle.
- MEM_TIMEOUT=4, mem_done never asserted → wb_err=1 after 4 WAIT cycles, back to IDLE.
- rst asserted mid-WAIT, then a stray mem_done → no wb_valid, IDLE.
- HALT packet → wb_halt pulse; ex_stall stays 1 while ex_valid is driven.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the EX/MEM memory-access stage.
package mem_access_stage_pkg;

  localparam int WORD_W = 16;
  localparam int REG_W  = 3;

  // Two-bit FSM encoding of the memory-access controller.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // Fields held across a multi-cycle memory access.
  typedef struct packed {
    logic [WORD_W-1:0] alu_result;
    logic [WORD_W-1:0] store_data;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic [REG_W-1:0]  wr_reg;
  } ex_fields_t;

  // Counter wide enough to hold MEM_TIMEOUT-1 with one spare bit.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

  // A memory op is rejected if it is both read and write, or word-misaligned.
  function automatic logic mem_op_illegal(input logic rd, input logic wr,
                                          input logic [WORD_W-1:0] addr);
    return (rd & wr) | addr[0];
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Request/done handshake bus between the memory-access stage and data memory.
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic              mem_req;
  logic              mem_wr;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_stall;
  logic              mem_done;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_wdata,
    input  mem_stall, mem_done, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_wdata,
    output mem_stall, mem_done, mem_rdata
  );

endinterface

// File: rtl/mem_access_stage_ex_mem_latch.sv
// Enable-loaded register bank holding the EX/MEM fields of the accepted packet.
module ex_mem_latch
  import mem_access_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_en,
  input  ex_fields_t d,
  output ex_fields_t q
);

  // Capture the execute packet when the controller accepts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load_en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM stage: accepts execute packets, runs the data-memory handshake for
// loads/stores, and emits a one-cycle registered writeback packet.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic [WORD_W-1:0]  ex_alu_result,
  input  logic [WORD_W-1:0]  ex_store_data,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic               ex_reg_write,
  input  logic [REG_W-1:0]   ex_wr_reg,
  input  logic               ex_halt,
  output logic               ex_stall,
  mem_access_stage_if.master mem,
  output logic               wb_valid,
  output logic [WORD_W-1:0]  wb_data,
  output logic [REG_W-1:0]   wb_reg,
  output logic               wb_reg_write,
  output logic               wb_err,
  output logic               wb_halt
);

  localparam int CNT_W = cnt_width(MEM_TIMEOUT);

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic               latch_en_s;
  ex_fields_t         lat_d_s, lat_q_s;

  logic               wb_valid_nxt_s, wb_err_nxt_s, wb_halt_nxt_s, wb_reg_write_nxt_s;
  logic [WORD_W-1:0]  wb_data_nxt_s;
  logic [REG_W-1:0]   wb_reg_nxt_s;

  assign lat_d_s = '{alu_result: ex_alu_result, store_data: ex_store_data,
                     mem_read: ex_mem_read, mem_write: ex_mem_write,
                     reg_write: ex_reg_write, wr_reg: ex_wr_reg};

  ex_mem_latch u_latch (
    .clk     (clk),
    .rst     (rst),
    .load_en (latch_en_s),
    .d       (lat_d_s),
    .q       (lat_q_s)
  );

  assign ex_stall      = (state_r != ST_IDLE);
  assign mem.mem_req   = (state_r == ST_REQ);
  assign mem.mem_wr    = lat_q_s.mem_write;
  assign mem.mem_addr  = lat_q_s.alu_result;
  assign mem.mem_wdata = lat_q_s.store_data;

  // Next-state, timeout counter and writeback packet selection.
  always_comb begin
    state_nxt_s        = state_r;
    cnt_nxt_s          = cnt_r;
    latch_en_s         = 1'b0;
    wb_valid_nxt_s     = 1'b0;
    wb_err_nxt_s       = 1'b0;
    wb_halt_nxt_s      = 1'b0;
    wb_reg_write_nxt_s = 1'b0;
    wb_data_nxt_s      = wb_data;
    wb_reg_nxt_s       = wb_reg;
    case (state_r)
      ST_IDLE: begin
        if (ex_valid) begin
          latch_en_s = 1'b1;
          if (ex_halt) begin
            wb_valid_nxt_s = 1'b1;
            wb_halt_nxt_s  = 1'b1;
            wb_data_nxt_s  = ex_alu_result;
            wb_reg_nxt_s   = ex_wr_reg;
            state_nxt_s    = ST_HALTED;
          end else if (!ex_mem_read && !ex_mem_write) begin
            wb_valid_nxt_s     = 1'b1;
            wb_reg_write_nxt_s = ex_reg_write;
            wb_data_nxt_s      = ex_alu_result;
            wb_reg_nxt_s       = ex_wr_reg;
          end else if (mem_op_illegal(ex_mem_read, ex_mem_write, ex_alu_result)) begin
            wb_valid_nxt_s = 1'b1;
            wb_err_nxt_s   = 1'b1;
            wb_data_nxt_s  = ex_alu_result;
            wb_reg_nxt_s   = ex_wr_reg;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!mem.mem_stall) begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem.mem_done) begin
          wb_valid_nxt_s     = 1'b1;
          wb_data_nxt_s      = lat_q_s.mem_read ? mem.mem_rdata : lat_q_s.alu_result;
          wb_reg_nxt_s       = lat_q_s.wr_reg;
          wb_reg_write_nxt_s = lat_q_s.reg_write & lat_q_s.mem_read;
          state_nxt_s        = ST_IDLE;
        end else if (cnt_r == CNT_W'(MEM_TIMEOUT - 1)) begin
          wb_valid_nxt_s = 1'b1;
          wb_err_nxt_s   = 1'b1;
          wb_data_nxt_s  = lat_q_s.alu_result;
          wb_reg_nxt_s   = lat_q_s.wr_reg;
          cnt_nxt_s      = {CNT_W{1'b0}};
          state_nxt_s    = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_HALTED: begin
        state_nxt_s = ST_HALTED;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered writeback outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      wb_valid     <= 1'b0;
      wb_data      <= {WORD_W{1'b0}};
      wb_reg       <= {REG_W{1'b0}};
      wb_reg_write <= 1'b0;
      wb_err       <= 1'b0;
      wb_halt      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      wb_valid     <= wb_valid_nxt_s;
      wb_data      <= wb_data_nxt_s;
      wb_reg       <= wb_reg_nxt_s;
      wb_reg_write <= wb_reg_write_nxt_s;
      wb_err       <= wb_err_nxt_s;
      wb_halt      <= wb_halt_nxt_s;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a writeback scoreboard.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  rg;
    logic        rw;
    logic        err;
    logic        halt;
    logic        chk_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_halt;
  logic [15:0] ex_alu_result, ex_store_data;
  logic [2:0]  ex_wr_reg;
  logic        ex_stall;
  logic        wb_valid, wb_reg_write, wb_err, wb_halt;
  logic [15:0] wb_data;
  logic [2:0]  wb_reg;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  mem_access_stage_if mem_bus ();

  mem_access_stage #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_wr_reg(ex_wr_reg), .ex_halt(ex_halt), .ex_stall(ex_stall),
    .mem(mem_bus.master),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg(wb_reg),
    .wb_reg_write(wb_reg_write), .wb_err(wb_err), .wb_halt(wb_halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic [2:0] r, input logic rw,
                      input logic err, input logic halt, input logic cd);
    exp_t e;
    e.data = d; e.rg = r; e.rw = rw; e.err = err; e.halt = halt; e.chk_data = cd;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [15:0] alu, input logic [15:0] sd, input logic rd,
                       input logic wr, input logic rw, input logic [2:0] r, input logic h);
    ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd; ex_mem_read = rd;
    ex_mem_write = wr; ex_reg_write = rw; ex_wr_reg = r; ex_halt = h;
  endtask

  task automatic idle_in();
    ex_valid = 1'b0; ex_alu_result = 16'hFFFF; ex_store_data = 16'h0000;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
    ex_wr_reg = 3'd0; ex_halt = 1'b0;
  endtask

  // Scoreboard: every writeback pulse must match the oldest expected packet.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      n_cmp++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL wb_unexpected: observed wb_valid=1 data=%0h expected no packet", wb_data);
      end
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.chk_data) begin
          chk("wb_data", 32'(wb_data), 32'(e.data));
          chk("wb_reg", 32'(wb_reg), 32'(e.rg));
        end
        chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
        chk("wb_err", 32'(wb_err), 32'(e.err));
        chk("wb_halt", 32'(wb_halt), 32'(e.halt));
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_in();
    mem_bus.mem_stall = 1'b0; mem_bus.mem_done = 1'b0; mem_bus.mem_rdata = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ex_stall", 32'(ex_stall), 32'd0);
    chk("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_mem_addr", 32'(mem_bus.mem_addr), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back non-memory packets.
    drive(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    push(16'h1234, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk); chk("alu_stall0", 32'(ex_stall), 32'd0);
    tick();
    drive(16'h5678, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0);
    push(16'h5678, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); chk("alu_wb1", 32'(wb_valid), 32'd1); chk("alu_stall1", 32'(ex_stall), 32'd0);
    tick();
    idle_in();
    @(negedge clk); chk("alu_wb2", 32'(wb_valid), 32'd1); chk("alu_stall2", 32'(ex_stall), 32'd0);
    tick();
    @(negedge clk); chk("alu_wb_end", 32'(wb_valid), 32'd0);

    // Load from 0x0040, done on the second WAIT cycle.
    drive(16'h0040, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
    push(16'hBEEF, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle_in();
    @(negedge clk);
    chk("ld_req", 32'(mem_bus.mem_req), 32'd1); chk("ld_stall_req", 32'(ex_stall), 32'd1);
    chk("ld_wr", 32'(mem_bus.mem_wr), 32'd0); chk("ld_addr", 32'(mem_bus.mem_addr), 32'h0040);
    tick();
    @(negedge clk); chk("ld_req_w1", 32'(mem_bus.mem_req), 32'd0); chk("ld_stall_w1", 32'(ex_stall), 32'd1);
    tick();
    mem_bus.mem_done = 1'b1; mem_bus.mem_rdata = 16'hBEEF;
    @(negedge clk); chk("ld_stall_w2", 32'(ex_stall), 32'd1);
    tick();
    mem_bus.mem_done = 1'b0; mem_bus.mem_rdata = 16'h0BAD;
    @(negedge clk); chk("ld_wb", 32'(wb_valid), 32'd1); chk("ld_stall_end", 32'(ex_stall), 32'd0);

    // Store to 0x0010 with three stalled request cycles.
    drive(16'h0010, 16'hA5A5, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0);
    push(16'h0010, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      mem_bus.mem_stall = (i < 3);
      @(negedge clk);
      chk("st_req", 32'(mem_bus.mem_req), 32'd1);
      chk("st_wr", 32'(mem_bus.mem_wr), 32'd1);
      chk("st_addr", 32'(mem_bus.mem_addr), 32'h0010);
      chk("st_wdata", 32'(mem_bus.mem_wdata), 32'hA5A5);
      tick();
    end
    mem_bus.mem_stall = 1'b0;
    mem_bus.mem_done = 1'b1;
    @(negedge clk); chk("st_req_wait", 32'(mem_bus.mem_req), 32'd0);
    tick();
    mem_bus.mem_done = 1'b0;
    @(negedge clk); chk("st_wb", 32'(wb_valid), 32'd1);

    // Misaligned load, then read+write together: immediate error, no request.
    drive(16'h0041, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0);
    push(16'h0041, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    idle_in();
    @(negedge clk);
    chk("mis_req", 32'(mem_bus.mem_req), 32'd0); chk("mis_wb", 32'(wb_valid), 32'd1);
    chk("mis_stall", 32'(ex_stall), 32'd0);
    tick();
    drive(16'h0020, 16'h1111, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0);
    push(16'h0020, 3'd6, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    idle_in();
    @(negedge clk);
    chk("rw_req", 32'(mem_bus.mem_req), 32'd0); chk("rw_wb", 32'(wb_valid), 32'd1);
    tick();

    // Timeout after four WAIT cycles without mem_done.
    drive(16'h0002, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0);
    push(16'h0002, 3'd7, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    idle_in();
    @(negedge clk); chk("to_req", 32'(mem_bus.mem_req), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_wait_stall", 32'(ex_stall), 32'd1);
      chk("to_wait_wb", 32'(wb_valid), 32'd0);
      tick();
    end
    @(negedge clk); chk("to_wb", 32'(wb_valid), 32'd1); chk("to_idle", 32'(ex_stall), 32'd0);
    tick();

    // Reset in WAIT drops the access; a late mem_done is ignored.
    drive(16'h0008, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
    tick();
    idle_in();
    tick();
    @(negedge clk); chk("rw8_wait", 32'(ex_stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_req", 32'(mem_bus.mem_req), 32'd0);
    chk("rst_async_stall", 32'(ex_stall), 32'd0);
    tick();
    rst = 1'b0;
    mem_bus.mem_done = 1'b1; mem_bus.mem_rdata = 16'hDEAD;
    tick();
    mem_bus.mem_done = 1'b0;
    @(negedge clk);
    chk("stray_wb", 32'(wb_valid), 32'd0); chk("stray_stall", 32'(ex_stall), 32'd0);
    tick();

    // HALT: one wb_halt pulse, then stalled for good.
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    push(16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(16'h4321, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
    @(negedge clk); chk("halt_wb", 32'(wb_valid), 32'd1); chk("halt_stall", 32'(ex_stall), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("halted_stall", 32'(ex_stall), 32'd1);
      chk("halted_wb", 32'(wb_valid), 32'd0);
    end
    tick();
    idle_in();
    tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
